gray_mem_arbiter: RTL and testbench
===================================

GRAY_MEM_ARBITER -- requirements
Module: gray_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, gray memory address width (128x128 image).
REQ-002 SHALL have parameter DATA_W, default 8, gray pixel width.
REQ-003 SHALL have parameter QUANTUM, default 16, maximum consecutive owned cycles while the other client waits; legal range 2..255.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have ports c0_req and c1_req, input, 1 each, client read request, held high while reads are wanted.
REQ-007 SHALL have ports c0_addr and c1_addr, input, ADDR_W each, client read address.
REQ-008 SHALL have ports c0_ready and c1_ready, output, 1 each, client owns the memory port this cycle.
REQ-009 SHALL have ports c0_valid and c1_valid, output, 1 each, read data for this client is on cN_data.
REQ-010 SHALL have ports c0_data and c1_data, output, DATA_W each, returned pixel; 0 when the matching valid is low.
REQ-011 SHALL have port mem_rd, output, 1, memory read strobe.
REQ-012 SHALL have port mem_addr, output, ADDR_W, memory read address; 0 when mem_rd is low.
REQ-013 SHALL have port mem_data, input, DATA_W, memory read data, valid exactly 1 cycle after mem_rd.
REQ-014 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, OWN0, OWN1; cN_ready SHALL be high only in OWNn.
REQ-016 In IDLE, next state SHALL be OWN of the requesting client; if both request, the winner SHALL follow REQ-029.
REQ-017 In OWNn, mem_rd SHALL equal cN_req and mem_addr SHALL equal cN_addr (combinational).
REQ-018 An 8-bit quantum counter SHALL clear on entry to any OWN state and increment each cycle spent in that state.
REQ-019 In OWNn with cN_req low, next state SHALL be OWN of the other client if it requests, else IDLE.
REQ-020 In OWNn with the counter at QUANTUM-1 and the other client requesting, next state SHALL be OWN of the other client, with no idle gap.
REQ-021 In OWNn with the counter at QUANTUM-1 and the other client not requesting, the state SHALL remain OWNn and the counter SHALL saturate at QUANTUM-1.
REQ-022 A registered tag SHALL capture mem_rd and the owner each cycle; cN_valid SHALL be high exactly 1 cycle after a mem_rd issued while OWNn, with cN_data equal to mem_data.
REQ-023 A read issued in the last cycle before an ownership switch SHALL still return to its issuing client, even if that client no longer owns the port.
REQ-024 last_owner SHALL update to n on every entry into OWNn.
REQ-025 busy SHALL be high in OWN0 and OWN1.

Reset
REQ-026 On reset assertion, state SHALL become IDLE, the counter SHALL become 0, last_owner SHALL become 1, and the tag SHALL clear, all immediately and asynchronously.
REQ-027 During reset and in the cycle after release, all outputs SHALL be 0: ready, valid, data, mem_rd, mem_addr, busy.
REQ-028 A read in flight when reset asserts SHALL be discarded, and no valid SHALL follow it.

Configuration
REQ-029 With macro GRAY_ARB_RR_EN defined, simultaneous requests from IDLE SHALL go to the client that is not last_owner (round-robin). Without it, client 0 SHALL always win from IDLE, and REQ-020 SHALL apply only when client 0 is waiting; OWN0 is then never pre-empted.

Verification
REQ-030 Scenario 1: only c0_req=1 with c0_addr=0x0081 from IDLE -> c0_ready=1 the next cycle, mem_rd=1 with mem_addr=0x0081, and c0_valid=1 one cycle later with c0_data equal to mem_data.
REQ-031 Scenario 2: both requests held high, RR_EN defined, QUANTUM=16 -> OWN0 for 16 cycles, then OWN1 for 16 cycles, then OWN0 again, with no cycle where both readies are low.
REQ-032 Scenario 3: switch at quantum expiry -> the read issued in the final OWN0 cycle returns c0_valid=1 while c1_ready=1, and c1_valid=0 in that same cycle.
REQ-033 Scenario 4: c0 drops its request after 3 cycles with c1 idle -> IDLE and busy=0 on the next cycle; then c1_req=1 alone -> OWN1.
REQ-034 Scenario 5: reset asserted mid-OWN1 with a read in flight -> c1_ready, mem_rd and c1_valid go to 0 at once, and after release a simultaneous request is granted to client 0.
REQ-035 Scenario 6: RR_EN undefined with both requesting constantly -> c0_ready held high indefinitely and c1_ready never asserted.

Source files
------------

// File: rtl/gray_mem_arbiter.sv
// Two-client read arbiter for a gray-level image memory with quantum-limited ownership.
// Define GRAY_ARB_RR_EN for round-robin tie-break and symmetric quantum pre-emption.
module gray_mem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int QUANTUM = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    output logic              c0_ready,
    output logic              c0_valid,
    output logic [DATA_W-1:0] c0_data,
    input  logic              c1_req,
    input  logic [ADDR_W-1:0] c1_addr,
    output logic              c1_ready,
    output logic              c1_valid,
    output logic [DATA_W-1:0] c1_data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] CNT_MAX = 8'(QUANTUM - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic       quantum_up;
    logic       tag_rd;
    logic       tag_owner;
`ifdef GRAY_ARB_RR_EN
    logic       last_owner;
`endif

    assign quantum_up = (cnt == CNT_MAX);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (c0_req && c1_req) begin
`ifdef GRAY_ARB_RR_EN
                    state_next = last_owner ? OWN0 : OWN1;
`else
                    state_next = OWN0;
`endif
                end else if (c0_req) begin
                    state_next = OWN0;
                end else if (c1_req) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!c0_req) begin
                    state_next = c1_req ? OWN1 : IDLE;
`ifdef GRAY_ARB_RR_EN
                end else if (quantum_up && c1_req) begin
                    state_next = OWN1;
`endif
                end
            end
            OWN1: begin
                if (!c1_req) begin
                    state_next = c0_req ? OWN0 : IDLE;
                end else if (quantum_up && c0_req) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port follows the owner; returned data is steered by the registered tag.
    always_comb begin
        c0_ready = (state == OWN0);
        c1_ready = (state == OWN1);
        busy     = (state != IDLE);
        mem_rd   = 1'b0;
        mem_addr = '0;
        if (state == OWN0 && c0_req) begin
            mem_rd   = 1'b1;
            mem_addr = c0_addr;
        end else if (state == OWN1 && c1_req) begin
            mem_rd   = 1'b1;
            mem_addr = c1_addr;
        end
        c0_valid = tag_rd && !tag_owner;
        c1_valid = tag_rd && tag_owner;
        c0_data  = c0_valid ? mem_data : '0;
        c1_data  = c1_valid ? mem_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            tag_rd    <= 1'b0;
            tag_owner <= 1'b0;
        end else begin
            state     <= state_next;
            tag_rd    <= mem_rd;
            tag_owner <= (state == OWN1);
            if (state_next != state) begin
                cnt <= 8'd0;
            end else if (state != IDLE && cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

`ifdef GRAY_ARB_RR_EN
    // Only the round-robin tie-break needs to remember who owned the port last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= 1'b1;
        end else if (state_next != state) begin
            if (state_next == OWN0) begin
                last_owner <= 1'b0;
            end else if (state_next == OWN1) begin
                last_owner <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Randomized self-checking bench for gray_mem_arbiter against a cycle-level ownership model.
// Honours GRAY_ARB_RR_EN in the reference model when the macro is defined.
module tb_gray_mem_arbiter;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int QUANTUM = 16;
    localparam int VW      = 6 + ADDR_W + 2 * DATA_W;
`ifdef GRAY_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              c0_req, c1_req;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic              c0_ready, c1_ready, c0_valid, c1_valid;
    logic [DATA_W-1:0] c0_data, c1_data;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic [VW-1:0]     obs;
    logic [VW-1:0]     exp;
    logic [DATA_W-1:0] salt;

    int checks   = 0;
    int failures = 0;

    int                m_owner;
    int                m_held;
    int                m_last;
    logic              m_pend;
    int                m_pend_owner;
    logic [DATA_W-1:0] m_pend_data;

    gray_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QUANTUM(QUANTUM)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_ready(c0_ready), .c0_valid(c0_valid), .c0_data(c0_data),
        .c1_req(c1_req), .c1_addr(c1_addr), .c1_ready(c1_ready), .c1_valid(c1_valid), .c1_data(c1_data),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {c0_ready, c1_ready, c0_valid, c1_valid, mem_rd, busy, mem_addr, c0_data, c1_data};

    function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] h;
        h = a ^ (a >> 6);
        return DATA_W'(h) ^ salt;
    endfunction

    // Synchronous image memory: data for a read appears one cycle later, junk otherwise.
    always @(posedge clk) begin
        mem_data <= mem_rd ? pix(mem_addr) : DATA_W'($urandom);
    end

    function automatic int req_of(input int c);
        return (c == 0) ? int'(c0_req) : int'(c1_req);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int c);
        return (c == 0) ? c0_addr : c1_addr;
    endfunction

    function automatic int next_owner();
        int o;
        o = m_owner;
        if (o < 0) begin
            if (c0_req && c1_req) return RR ? 1 - m_last : 0;
            if (c0_req) return 0;
            if (c1_req) return 1;
            return -1;
        end
        if (req_of(o) == 0) return (req_of(1 - o) != 0) ? 1 - o : -1;
        if (m_held + 1 >= QUANTUM && req_of(1 - o) != 0 && (RR || o == 1)) return 1 - o;
        return o;
    endfunction

    // Reference model: owner -1 means idle; m_held counts cycles already spent owning.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner      <= -1;
            m_held       <= 0;
            m_last       <= 1;
            m_pend       <= 1'b0;
            m_pend_owner <= 0;
            m_pend_data  <= '0;
        end else begin
            m_owner      <= next_owner();
            m_held       <= (next_owner() == m_owner) ? m_held + 1 : 0;
            if (next_owner() >= 0 && next_owner() != m_owner) m_last <= next_owner();
            m_pend       <= (m_owner >= 0) && (req_of(m_owner) != 0);
            m_pend_owner <= m_owner;
            m_pend_data  <= pix(addr_of(m_owner));
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic rd, v0, v1;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d0, d1;
        rd = (m_owner >= 0) && (req_of(m_owner) != 0);
        v0 = m_pend && (m_pend_owner == 0);
        v1 = m_pend && (m_pend_owner == 1);
        a  = rd ? addr_of(m_owner) : '0;
        d0 = v0 ? m_pend_data : '0;
        d1 = v1 ? m_pend_data : '0;
        return {m_owner == 0, m_owner == 1, v0, v1, rd, m_owner >= 0, a, d0, d1};
    endfunction

    task automatic go_idle();
        c0_req = 1'b0;
        c1_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        c0_req  = 1'b1;
        c1_req  = 1'b0;
        c0_addr = ADDR_W'($urandom);
        c1_addr = ADDR_W'($urandom);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got %h expected 0", obs);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL reset_release: got %h expected 0", obs);
        end
        @(negedge clk);
        #1;
        checks++;
        exp = exp_vec();
        if (obs !== exp || c0_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_first_grant: got %h expected %h", obs, exp);
        end
        go_idle();
    endtask

    task automatic test_single();
        c0_req  = 1'b1;
        c1_req  = 1'b0;
        c0_addr = 14'h0081;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL single_idle: got %h expected 0", obs);
        end
        @(negedge clk);
        #1;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0081, 8'h00, 8'h00};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL single_grant: got %h expected %h", obs, exp);
        end
        @(negedge clk);
        c0_req = 1'b0;
        #1;
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 14'h0000, pix(14'h0081), 8'h00};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL single_return: got %h expected %h", obs, exp);
        end
        go_idle();
    endtask

    task automatic test_quantum();
        c0_req = 1'b1;
        c1_req = 1'b1;
        for (int i = 0; i < 3 * QUANTUM + 6; i++) begin
            c0_addr = ADDR_W'($urandom);
            c1_addr = ADDR_W'($urandom);
            #1;
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL quantum cycle %0d: got %h expected %h", i, obs, exp);
            end
            if (i > 0) begin
                checks++;
                if (!(c0_ready || c1_ready)) begin
                    failures++;
                    $display("[TB] FAIL quantum_gap cycle %0d: readies %b%b expected one high", i, c0_ready, c1_ready);
                end
            end
            @(negedge clk);
        end
        go_idle();
    endtask

    task automatic test_release();
        c0_req = 1'b1;
        c1_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) c0_req = 1'b0;
            if (i == 5) c1_req = 1'b1;
            c0_addr = ADDR_W'($urandom);
            c1_addr = ADDR_W'($urandom);
            #1;
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL release cycle %0d: got %h expected %h", i, obs, exp);
            end
            if (i == 5) begin
                checks++;
                if (busy !== 1'b0 || c0_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL release_idle: busy %b ready0 %b expected 0 0", busy, c0_ready);
                end
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (c1_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_own1: ready1 %b busy %b expected 1 1", c1_ready, busy);
        end
        go_idle();
    endtask

    task automatic test_reset_inflight();
        c0_req = 1'b0;
        c1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c1_addr = ADDR_W'($urandom);
            #1;
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL inflight cycle %0d: got %h expected %h", i, obs, exp);
            end
            if (i < 3) @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL inflight_reset: got %h expected 0", obs);
        end
        c0_req = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL inflight_release: got %h expected 0", obs);
        end
        @(negedge clk);
        #1;
        exp = exp_vec();
        checks++;
        if (obs !== exp || c0_ready !== 1'b1 || c1_ready !== 1'b0 || c1_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL inflight_regrant: got %h expected %h with client 0 owning", obs, exp);
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) c0_req = ~c0_req;
            if ($urandom_range(0, 3) == 0) c1_req = ~c1_req;
            c0_addr = ADDR_W'($urandom);
            c1_addr = ADDR_W'($urandom);
            #1;
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", i, obs, exp);
            end
            @(negedge clk);
        end
        go_idle();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        salt = DATA_W'($urandom);
        test_reset();
        test_single();
        test_quantum();
        test_release();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
